cic_decim_comb: RTL and testbench
=================================

Name: cic_decim_comb

Overview:
Decimate-and-comb back end of the CIC decimation chain. It sits directly downstream of the last integrator stage and consumes that stage's output word stream. It keeps one sample in every R, then passes the kept sample through N pipelined comb (first-difference, M=1) stages. The result is a decimated sample stream with a one-cycle valid strobe.

Parameters:
W, 10, data width in bits; the same width as the integrator chain, with no growth or truncation.
R, 4, decimation ratio (>=1); one in every R valid input samples is kept.
N, 2, number of comb stages (>=1); normally equal to the integrator stage count.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  asynchronous active-high reset.
din  input  W  integrator chain output, unsigned/two's-complement word; it wraps modulo 2^W.
din_vld  input  1  din is valid this cycle. Tie high when the integrators run every clock.
dout  output  W  comb chain output (decimated, differenced sample).
dout_vld  output  1  single-cycle strobe: dout holds a new sample.

Behaviour:
- Reset (rst=1, asynchronous): the following are all cleared to 0.
  - phase counter cnt
  - capture register s0 and its valid v0
  - every comb delay register d1..dN
  - every comb output register s1..sN and its valid v1..vN
  - dout=0, dout_vld=0
- Reset mid-stream: in-flight samples are discarded. After release, the first kept sample is the R-th valid din.
- Phase counter:
  - width max(1, clog2(R)).
  - On each edge with din_vld=1: cnt increments, wrapping R-1 -> 0. With din_vld=0, cnt holds.
- Decimation strobe: dec = din_vld & (cnt==R-1).
  - On an edge with dec=1: s0 <= din.
  - v0 <= dec on every edge, so v0 is high for exactly one cycle per kept sample.
  - With R=1, every valid din is kept.
- Comb stage k (1..N), on an edge with v(k-1)=1:
  - sk <= s(k-1) - dk
  - dk <= s(k-1)
  - Otherwise sk and dk hold.
  - vk <= v(k-1) on every edge.
- Arithmetic: W-bit subtraction modulo 2^W; borrow and carry are discarded. The wrap is mandatory because CIC correctness relies on it. No saturation.
- dout = sN (registered). dout_vld = vN.
- dout holds its last value between strobes.
- Latency: a din kept at edge E appears on dout with dout_vld=1 after edge E+N, i.e. N+1 edges from acceptance.
- Throughput: one kept sample per clock is sustained (R=1 with din_vld tied high). Back-to-back valids propagate without stall or loss.
- Delay registers start at 0. The first N outputs after reset are therefore start-up transients and are not special-cased.
- din_vld gaps: the counter and pipeline advance only as described above. Samples are never duplicated or dropped.
- No backpressure: the consumer must accept dout whenever dout_vld=1.
- Parameter legality: R>=1, N>=1, W>=2. Other values are not supported.

Test Plan:
1. Ramp decimation. W=10, R=4, N=2, din_vld=1, din=0,1,2,... per cycle.
   -> kept samples 3,7,11,15
   -> comb1 outputs 3,4,4,4
   -> dout sequence 3,1,0,0,...
   -> dout_vld pulses every 4th cycle, first pulse 3 edges after din=3 is accepted.
2. Modulo wrap. R=1, N=1, kept samples 1000 then 8.
   -> dout = 1000, then (8-1000) mod 1024 = 32.
   -> Then kept sample 8 again gives dout=0. No saturation.
3. din_vld gaps. R=4, din_vld toggles 1,0,1,0,... with din=0,1,2,...
   -> cnt advances only on valid cycles.
   -> Kept samples are the 4th, 8th, ... valid words, i.e. din = 6, 14, ...
   -> Exactly one dout_vld per 4 valid inputs.
4. Full throughput. R=1, N=3, din_vld=1, din=k^2 for k=0..
   -> Third difference settles to 0 after the 3-sample start-up transient.
   -> dout_vld is continuously high starting 4 edges after the first valid.
5. Async reset mid-operation. Assert rst asynchronously (between edges) while v1 is high.
   -> dout=0 and dout_vld=0 immediately, with no pending strobe after release.
   -> The next dout_vld comes after R new valid inputs plus N+1 edges.
6. Hold behaviour. After a strobe with dout=5, drive din_vld=0 for 20 cycles.
   -> dout stays 5, dout_vld stays 0, cnt unchanged.

Source files
------------

// File: rtl/cic_decim_comb.sv
// cic_decim_comb: decimate-by-R and N-stage comb (M=1) back end of a CIC decimator.
// Keeps one in every R valid input words. Each kept word then passes through N
// pipelined first-difference stages, using W-bit arithmetic that wraps modulo 2^W.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   din      integrator chain output word (wraps modulo 2^W)
//   din_vld  din is valid this cycle
//   dout     comb chain output (registered, holds between strobes)
//   dout_vld single-cycle strobe marking a new dout sample
module cic_decim_comb #(
    parameter int unsigned W = 10,
    parameter int unsigned R = 4,
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_vld,
    output logic [W-1:0] dout,
    output logic         dout_vld
);

    localparam int unsigned CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

    logic [CW-1:0] cnt;
    logic          dec;

    // Index 0 is the capture stage; indices 1..N are the comb stages.
    logic [W-1:0] s [0:N];
    logic [W-1:0] d [1:N];
    logic         v [0:N];

    assign dec = din_vld && (cnt == CNT_LAST);

    // Phase counter: advances only on valid input words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (din_vld) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
    end

    // Capture register followed by the comb pipeline. Subtraction wraps by design.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s[0] <= '0;
            v[0] <= 1'b0;
            for (int k = 1; k <= int'(N); k++) begin
                s[k] <= '0;
                d[k] <= '0;
                v[k] <= 1'b0;
            end
        end else begin
            v[0] <= dec;
            if (dec) begin
                s[0] <= din;
            end
            for (int k = 1; k <= int'(N); k++) begin
                v[k] <= v[k-1];
                if (v[k-1]) begin
                    s[k] <= s[k-1] - d[k];
                    d[k] <= s[k-1];
                end
            end
        end
    end

    assign dout     = s[N];
    assign dout_vld = v[N];

endmodule

// File: tb/tb_cic_decim_comb.sv
// tb_cic_decim_comb: directed, self-checking bench for cic_decim_comb.
// Three instances cover (R=4,N=2), (R=1,N=1) and (R=1,N=3); all share clk and rst.
module tb_cic_decim_comb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] a_din = '0, b_din = '0, c_din = '0;
    logic       a_vld = 1'b0, b_vld = 1'b0, c_vld = 1'b0;
    logic [9:0] a_dout, b_dout, c_dout;
    logic       a_dvld, b_dvld, c_dvld;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [9:0] din;
        logic       vld;
        logic [9:0] exp_dout;
        logic       exp_vld;
    } vec_t;

    vec_t tbl [20];

    always #5 clk = ~clk;

    cic_decim_comb #(.W(10), .R(4), .N(2)) u_a (
        .clk(clk), .rst(rst), .din(a_din), .din_vld(a_vld), .dout(a_dout), .dout_vld(a_dvld)
    );
    cic_decim_comb #(.W(10), .R(1), .N(1)) u_b (
        .clk(clk), .rst(rst), .din(b_din), .din_vld(b_vld), .dout(b_dout), .dout_vld(b_dvld)
    );
    cic_decim_comb #(.W(10), .R(1), .N(3)) u_c (
        .clk(clk), .rst(rst), .din(c_din), .din_vld(c_vld), .dout(c_dout), .dout_vld(c_dvld)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [9:0] act_d, input logic act_v,
                         input logic [9:0] exp_d, input logic exp_v);
        n_cmp++;
        if (act_d !== exp_d || act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s[%0d]: got dout=%0d vld=%b, expected dout=%0d vld=%b",
                     name, idx, act_d, act_v, exp_d, exp_v);
        end
    endtask

    task automatic do_reset;
        a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] e_d;
        logic       e_v;

        // Ramp vectors for R=4, N=2: kept 3,7,11,15 -> dout 3,1,0,0.
        for (int i = 0; i < 20; i++) begin
            tbl[i].din      = 10'(i);
            tbl[i].vld      = 1'b1;
            tbl[i].exp_dout = 10'd0;
            tbl[i].exp_vld  = 1'b0;
        end
        for (int i = 5; i <= 8; i++)  tbl[i].exp_dout = 10'd3;
        for (int i = 9; i <= 12; i++) tbl[i].exp_dout = 10'd1;
        tbl[5].exp_vld  = 1'b1;
        tbl[9].exp_vld  = 1'b1;
        tbl[13].exp_vld = 1'b1;
        tbl[17].exp_vld = 1'b1;

        // Reset state of all instances.
        tick;
        tick;
        check("reset_a", 0, a_dout, a_dvld, 10'd0, 1'b0);
        check("reset_b", 0, b_dout, b_dvld, 10'd0, 1'b0);
        check("reset_c", 0, c_dout, c_dvld, 10'd0, 1'b0);
        rst = 1'b0;

        // Ramp decimation, table-driven.
        for (int i = 0; i < 20; i++) begin
            a_din = tbl[i].din;
            a_vld = tbl[i].vld;
            tick;
            check("ramp", i, a_dout, a_dvld, tbl[i].exp_dout, tbl[i].exp_vld);
        end

        // Async reset while comb stage 1 holds a pending sample and dout=3.
        do_reset;
        for (int j = 0; j < 9; j++) begin
            a_din = 10'(j);
            a_vld = 1'b1;
            tick;
        end
        check("pre_async_rst", 0, a_dout, a_dvld, 10'd3, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 0, a_dout, a_dvld, 10'd0, 1'b0);
        tick;
        tick;
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            a_din = 10'(100 + j);
            a_vld = 1'b1;
            tick;
            check("post_rst", j, a_dout, a_dvld, (j == 5) ? 10'd103 : 10'd0, j == 5);
        end
        a_vld = 1'b0;

        // din_vld gaps: kept words 6, 14, 22 -> dout 6, 2, 0 at edges 8, 16, 24.
        do_reset;
        for (int i = 0; i < 26; i++) begin
            a_din = 10'(i);
            a_vld = (i % 2 == 0);
            tick;
            e_v = (i == 8) || (i == 16) || (i == 24);
            e_d = (i < 8) ? 10'd0 : (i < 16) ? 10'd6 : (i < 24) ? 10'd2 : 10'd0;
            check("gaps", i, a_dout, a_dvld, e_d, e_v);
        end
        a_vld = 1'b0;

        // Counter holds across an idle stretch: 2 valids, 20 idle, 2 valids.
        do_reset;
        a_vld = 1'b1; a_din = 10'd50; tick;
        a_din = 10'd51; tick;
        a_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            check("cnt_hold", i, a_dout, a_dvld, 10'd0, 1'b0);
        end
        a_vld = 1'b1; a_din = 10'd52; tick;
        a_din = 10'd53; tick;
        a_vld = 1'b0;
        check("cnt_resume", 0, a_dout, a_dvld, 10'd0, 1'b0);
        tick;
        check("cnt_resume", 1, a_dout, a_dvld, 10'd0, 1'b0);
        tick;
        check("cnt_resume", 2, a_dout, a_dvld, 10'd53, 1'b1);

        // Modulo wrap on R=1, N=1, then hold after a strobe with dout=5.
        do_reset;
        b_vld = 1'b1; b_din = 10'd1000; tick;
        check("wrap", 0, b_dout, b_dvld, 10'd0, 1'b0);
        b_din = 10'd8; tick;
        check("wrap", 1, b_dout, b_dvld, 10'd1000, 1'b1);
        b_din = 10'd8; tick;
        check("wrap", 2, b_dout, b_dvld, 10'd32, 1'b1);
        b_vld = 1'b0; tick;
        check("wrap", 3, b_dout, b_dvld, 10'd0, 1'b1);
        tick;
        check("wrap", 4, b_dout, b_dvld, 10'd0, 1'b0);
        b_vld = 1'b1; b_din = 10'd13; tick;
        b_vld = 1'b0; b_din = 10'd999; tick;
        check("hold_strobe", 0, b_dout, b_dvld, 10'd5, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick;
            check("hold", i, b_dout, b_dvld, 10'd5, 1'b0);
        end

        // Full throughput, R=1, N=3, din=k^2: third difference 0,1,1,0,0,...
        do_reset;
        for (int k = 0; k < 13; k++) begin
            c_din = 10'(k * k);
            c_vld = 1'b1;
            tick;
            e_v = (k >= 3);
            e_d = (k == 4 || k == 5) ? 10'd1 : 10'd0;
            check("throughput", k, c_dout, c_dvld, e_d, e_v);
        end
        c_vld = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
